// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store engine sitting between the core's memory stage
// and a word-wide, byte-addressable RAM. Handles byte/half/word accesses with
// sign or zero extension, and builds sub-word stores as read-modify-write
// because the RAM can only write whole words. Every RAM-facing output comes
// straight from a flop so the write strobe and address never glitch.
module mem_access_unit #(
  parameter int unsigned MEM_SZ = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsgn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_data_out
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state;
  state_t next_state;

  // Request fields captured at accept; only the low half of the store data is
  // kept because word stores hand wdata to the RAM directly at accept time.
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_unsgn;
  logic [1:0]  op_lane;
  logic [15:0] op_wdata;

  logic        accept;
  logic        req_err;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  // Pick the addressed byte or half out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(
    input logic [31:0] word,
    input logic [1:0]  sz,
    input logic [1:0]  lane,
    input logic        zext
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: r = zext ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = zext ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the store byte or half onto the word read back from the RAM.
  function automatic logic [31:0] merge_store(
    input logic [31:0] word,
    input logic [15:0] data,
    input logic [1:0]  sz,
    input logic [1:0]  lane
  );
    logic [31:0] r;
    r = word;
    if (sz == SZ_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else begin
      if (lane[1]) begin
        r[31:16] = data;
      end else begin
        r[15:0] = data;
      end
    end
    return r;
  endfunction

  assign ready  = (state == IDLE);
  assign accept = req && (state == IDLE);

  // Reject illegal sizes, misaligned halves/words and addresses past the RAM.
  always_comb begin
    req_err = 1'b0;
    if (size == 2'b11) begin
      req_err = 1'b1;
    end
    if ((size == SZ_HALF) && addr[0]) begin
      req_err = 1'b1;
    end
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
    if (addr >= MEM_SZ) begin
      req_err = 1'b1;
    end
  end

  // Read-side datapath: lane extraction for loads, merge for sub-word stores.
  always_comb begin
    load_value  = extract_load(mem_data_out, op_size, op_lane, op_unsgn);
    merged_word = merge_store(mem_data_out, op_wdata, op_size, op_lane);
  end

  // State register; reset abandons whatever access is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: errors skip the RAM, word stores skip the read.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            next_state = DONE;
          end else if (we && (size == SZ_WORD)) begin
            next_state = WR;
          end else begin
            next_state = RD;
          end
        end
      end
      RD: begin
        next_state = op_we ? WR : DONE;
      end
      WR: begin
        next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture the request fields on accept so the core may change its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we    <= 1'b0;
      op_size  <= SZ_BYTE;
      op_unsgn <= 1'b0;
      op_lane  <= 2'b00;
      op_wdata <= 16'h0000;
    end else if (accept) begin
      op_we    <= we;
      op_size  <= size;
      op_unsgn <= unsgn;
      op_lane  <= addr[1:0];
      op_wdata <= wdata[15:0];
    end
  end

  // Registered strobes follow the state being entered, so they are exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_read  <= (next_state == RD);
      mem_write <= (next_state == WR);
      done      <= (next_state == DONE);
      err       <= accept && req_err;
    end
  end

  // RAM address is loaded once per access, only when the RAM will be used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= 32'h0000_0000;
    end else if (accept && !req_err) begin
      mem_address <= {addr[31:2], 2'b00};
    end
  end

  // Write data: raw store data for word stores, merged word for sub-word ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data_in <= 32'h0000_0000;
    end else if (accept && !req_err && we && (size == SZ_WORD)) begin
      mem_data_in <= wdata;
    end else if ((state == RD) && op_we) begin
      mem_data_in <= merged_word;
    end
  end

  // Load result is updated only by successful loads and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0000_0000;
    end else if ((state == RD) && !op_we) begin
      rdata <= load_value;
    end
  end

endmodule
